// File: rtl/ser_add_seq.sv
// Sequencer that feeds operand pairs to an external bit-serial adder and returns {carry, result}.
// Define SER_ADD_SEQ_FIFO_EN for a 4-entry operand FIFO; default is a single holding register.
module ser_add_seq #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             add_reset,
    output logic             add_load,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_result,
    input  logic             add_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             busy
);

    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {IDLE, CLR, LOAD, WAIT, HOLD} state_t;

    state_t           state, state_nxt;
    logic             push, pop, store_empty;
    logic             capture, out_take;
    logic [WIDTH-1:0] head_a, head_b;
    logic [WIDTH-1:0] op_a, op_b;
    logic [CW-1:0]    count;

    assign push = in_valid & in_ready;

`ifdef SER_ADD_SEQ_FIFO_EN
    logic [WIDTH-1:0] fifo_a [4];
    logic [WIDTH-1:0] fifo_b [4];
    logic [1:0]       wr_ptr, rd_ptr;
    logic [2:0]       fill;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                fifo_a[i] <= '0;
                fifo_b[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                fifo_a[wr_ptr] <= in_a;
                fifo_b[wr_ptr] <= in_b;
                wr_ptr         <= wr_ptr + 2'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   fill <= fill + 3'd1;
                2'b01:   fill <= fill - 3'd1;
                default: fill <= fill;
            endcase
        end
    end

    assign in_ready    = (fill != 3'd4);
    assign store_empty = (fill == 3'd0);
    assign head_a      = fifo_a[rd_ptr];
    assign head_b      = fifo_b[rd_ptr];
`else
    logic             hold_full;
    logic [WIDTH-1:0] hold_a, hold_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_a    <= '0;
            hold_b    <= '0;
        end else if (push) begin
            hold_full <= 1'b1;
            hold_a    <= in_a;
            hold_b    <= in_b;
        end else if (pop) begin
            hold_full <= 1'b0;
        end
    end

    assign in_ready    = ~hold_full;
    assign store_empty = ~hold_full;
    assign head_a      = hold_a;
    assign head_b      = hold_b;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        out_take  = 1'b0;
        case (state)
            IDLE: begin
                if (!store_empty) begin
                    pop       = 1'b1;
                    state_nxt = CLR;
                end
            end
            CLR:  state_nxt = LOAD;
            LOAD: state_nxt = WAIT;
            WAIT: begin
                if (count == CW'(SETTLE - 1)) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    out_take = 1'b1;
                    if (!store_empty) begin
                        pop       = 1'b1;
                        state_nxt = CLR;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a      <= '0;
            op_b      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else begin
            if (pop) begin
                op_a <= head_a;
                op_b <= head_b;
            end
            if (state == LOAD)
                count <= '0;
            else if (state == WAIT)
                count <= count + 1'b1;
            if (capture) begin
                out_sum   <= {add_carry, add_result};
                out_valid <= 1'b1;
            end else if (out_take) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Adder clear is combinational so the adder is held clear for the whole reset pulse.
    assign add_reset = reset | (state == CLR);
    assign add_load  = (state == LOAD);
    assign add_a     = op_a;
    assign add_b     = op_b;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ser_add_seq.sv
// Directed self-checking bench for ser_add_seq with a behavioural serial-adder model.
module tb_ser_add_seq;

    localparam int W = 8;
`ifdef SER_ADD_SEQ_FIFO_EN
    localparam bit FIFO = 1'b1;
`else
    localparam bit FIFO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic         add_reset, add_load;
    logic [W-1:0] add_a, add_b;
    logic [W-1:0] add_result;
    logic         add_carry;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out_sum;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ser_add_seq #(.WIDTH(W), .SETTLE(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .add_reset  (add_reset),
        .add_load   (add_load),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .add_carry  (add_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .busy       (busy)
    );

    // Serial adder stand-in: result is only valid W cycles after the load strobe.
    logic [W:0]  acc;
    int unsigned settle_cnt;
    always @(posedge clk) begin
        if (add_reset) begin
            acc        <= '0;
            settle_cnt <= 0;
        end else if (add_load) begin
            acc        <= {1'b0, add_a} + {1'b0, add_b};
            settle_cnt <= W;
        end else if (settle_cnt != 0) begin
            settle_cnt <= settle_cnt - 1;
        end
    end
    assign add_result = (settle_cnt == 0) ? acc[W-1:0] : '0;
    assign add_carry  = (settle_cnt == 0) ? acc[W] : 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept", 32'(n < 50), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic take(input logic [W:0] exp, input string tag);
        wait_valid({tag, "_valid"});
        chk(tag, 32'(out_sum), 32'(exp));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_clear"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int edges, rst_cnt, load_cnt;
        bit ordered, prev_rst;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum",   32'(out_sum),   32'd0);
        chk("rst_add_load",  32'(add_load),  32'd0);
        chk("rst_add_reset", 32'(add_reset), 32'd1);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_add_a",     32'(add_a),     32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready",  32'(in_ready),  32'd1);
        chk("idle_add_reset", 32'(add_reset), 32'd0);

        // 7+3 from idle: latency, one clear pulse followed by one load pulse
        push(8'd7, 8'd3);
        edges = 0; rst_cnt = 0; load_cnt = 0; ordered = 1'b1; prev_rst = 1'b0;
        while (!out_valid && edges < 100) begin
            if (add_reset) rst_cnt++;
            if (add_load) begin
                load_cnt++;
                if (!prev_rst) ordered = 1'b0;
            end
            prev_rst = add_reset;
            @(negedge clk);
            edges++;
        end
        chk("lat_edges",    32'(edges),    32'd13);
        chk("lat_sum",      32'(out_sum),  32'h00A);
        chk("lat_rst_cnt",  32'(rst_cnt),  32'd1);
        chk("lat_load_cnt", 32'(load_cnt), 32'd1);
        chk("lat_order",    32'(ordered),  32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("lat_clear", 32'(out_valid), 32'd0);
        chk("lat_idle",  32'(busy),      32'd0);

        // carry into bit WIDTH, in order
        push(8'd255, 8'd1);
        push(8'd255, 8'd255);
        take(9'h100, "sum_100");
        take(9'h1FE, "sum_1fe");

        // push during WAIT, then hold out_ready low in HOLD
        push(8'd1, 8'd2);
        repeat (5) @(negedge clk);
        chk("wait_busy", 32'(busy), 32'd1);
        push(8'd3, 8'd4);
        chk("queued_ready", 32'(in_ready), 32'(FIFO));
        wait_valid("hold_valid");
        for (int i = 0; i < 20; i++) begin
            chk("hold_sum",   32'(out_sum),   32'h003);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_load",  32'(add_load),  32'd0);
            chk("hold_ready", 32'(in_ready),  32'(FIFO));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("pop_ready",     32'(in_ready),  32'd1);
        chk("pop_add_reset", 32'(add_reset), 32'd1);
        take(9'h007, "sum_007");

        // reset asserted in WAIT cycle 4
        push(8'd9, 8'd9);
        repeat (7) @(negedge clk);
        chk("midwait_add_a", 32'(add_a), 32'd9);
        reset = 1'b1;
        #1;
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_out_sum",   32'(out_sum),   32'd0);
        chk("mr_add_load",  32'(add_load),  32'd0);
        chk("mr_add_reset", 32'(add_reset), 32'd1);
        chk("mr_add_a",     32'(add_a),     32'd0);
        chk("mr_add_b",     32'(add_b),     32'd0);
        chk("mr_busy",      32'(busy),      32'd0);
        chk("mr_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        push(8'd6, 8'd4);
        take(9'h00A, "post_rst");
        chk("post_rst_idle", 32'(busy), 32'd0);

`ifdef SER_ADD_SEQ_FIFO_EN
        // one sum parked in HOLD, then four queued, fifth refused
        push(8'd20, 8'd30);
        wait_valid("fifo_first");
        chk("fifo_rdy1", 32'(in_ready), 32'd1);
        push(8'd6, 8'd4);
        chk("fifo_rdy2", 32'(in_ready), 32'd1);
        push(8'd1, 8'd2);
        chk("fifo_rdy3", 32'(in_ready), 32'd1);
        push(8'd7, 8'd7);
        chk("fifo_rdy4", 32'(in_ready), 32'd1);
        push(8'd100, 8'd200);
        chk("fifo_full", 32'(in_ready), 32'd0);
        take(9'h032, "fifo_s0");
        take(9'h00A, "fifo_s1");
        take(9'h003, "fifo_s2");
        take(9'h00E, "fifo_s3");
        take(9'h12C, "fifo_s4");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
